// File: rtl/rv_decode_stage.sv
// Registered RV32I/RV64I integer decode stage with valid/ready handshakes on both sides.
// Latency 1 cycle; in_ready = !out_valid || out_ready, so the bundle holds while downstream stalls.
module rv_decode_stage #(
    parameter int XLEN      = 32,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [XLEN-1:0]      in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [4:0]           out_alu_op,
    output logic [4:0]           out_rs1,
    output logic [4:0]           out_rs2,
    output logic [4:0]           out_rd,
    output logic [XLEN-1:0]      out_imm,
    output logic                 out_alu_src,
    output logic                 out_reg_write,
    output logic                 out_reg_read,
    output logic                 out_illegal,
    output logic [ILL_CNT_W-1:0] ill_count
);
    localparam int SHW = (XLEN == 64) ? 6 : 5;

    logic            accept;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [SHW-1:0]  shamt;
    logic            sh_hi_zero;
    logic            sh_hi_sra;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_sh;

    logic [4:0]      d_alu_op;
    logic [4:0]      d_rs1;
    logic [4:0]      d_rs2;
    logic [4:0]      d_rd;
    logic [XLEN-1:0] d_imm;
    logic            d_alu_src;
    logic            d_reg_write;
    logic            d_reg_read;
    logic            d_legal;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign opcode   = in_instr[6:0];
    assign funct3   = in_instr[14:12];
    assign funct7   = in_instr[31:25];
    assign shamt    = in_instr[20 +: SHW];

    // At XLEN=64 bit 25 belongs to shamt; at XLEN=32 it must be zero.
    always_comb begin
        if (XLEN == 64) begin
            sh_hi_zero = (in_instr[31:26] == 6'b000000);
            sh_hi_sra  = (in_instr[31:26] == 6'b010000);
        end else begin
            sh_hi_zero = (in_instr[31:25] == 7'b0000000);
            sh_hi_sra  = (in_instr[31:25] == 7'b0100000);
        end
    end

    always_comb begin
        imm_i        = {XLEN{in_instr[31]}};
        imm_i[11:0]  = in_instr[31:20];
        imm_u        = {XLEN{in_instr[31]}};
        imm_u[31:0]  = {in_instr[31:12], 12'b0};
        imm_sh       = '0;
        imm_sh[SHW-1:0] = shamt;
    end

    always_comb begin
        d_alu_op    = 5'd0;
        d_rs1       = 5'd0;
        d_rs2       = 5'd0;
        d_rd        = 5'd0;
        d_imm       = '0;
        d_alu_src   = 1'b0;
        d_reg_write = 1'b0;
        d_reg_read  = 1'b0;
        d_legal     = 1'b0;
        case (opcode)
            7'b0110011: begin
                d_rs1       = in_instr[19:15];
                d_rs2       = in_instr[24:20];
                d_rd        = in_instr[11:7];
                d_reg_read  = 1'b1;
                d_reg_write = 1'b1;
                d_legal     = (funct7 == 7'b0000000) ||
                              (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
                case (funct3)
                    3'b000:  d_alu_op = funct7[5] ? 5'd2 : 5'd0;
                    3'b001:  d_alu_op = 5'd9;
                    3'b010:  d_alu_op = 5'd15;
                    3'b011:  d_alu_op = 5'd17;
                    3'b100:  d_alu_op = 5'd3;
                    3'b101:  d_alu_op = funct7[5] ? 5'd13 : 5'd11;
                    3'b110:  d_alu_op = 5'd5;
                    default: d_alu_op = 5'd7;
                endcase
            end
            7'b0010011: begin
                d_rs1       = in_instr[19:15];
                d_rd        = in_instr[11:7];
                d_alu_src   = 1'b1;
                d_reg_read  = 1'b1;
                d_reg_write = 1'b1;
                d_imm       = imm_i;
                d_legal     = 1'b1;
                case (funct3)
                    3'b000:  d_alu_op = 5'd1;
                    3'b010:  d_alu_op = 5'd16;
                    3'b011:  d_alu_op = 5'd18;
                    3'b100:  d_alu_op = 5'd4;
                    3'b110:  d_alu_op = 5'd6;
                    3'b111:  d_alu_op = 5'd8;
                    3'b001: begin
                        d_alu_op = 5'd10;
                        d_imm    = imm_sh;
                        d_legal  = sh_hi_zero;
                    end
                    default: begin
                        d_alu_op = in_instr[30] ? 5'd14 : 5'd12;
                        d_imm    = imm_sh;
                        d_legal  = sh_hi_zero || sh_hi_sra;
                    end
                endcase
            end
            7'b0110111, 7'b0010111: begin
                d_rd        = in_instr[11:7];
                d_alu_src   = 1'b1;
                d_reg_write = 1'b1;
                d_imm       = imm_u;
                d_alu_op    = opcode[5] ? 5'd19 : 5'd20;
                d_legal     = 1'b1;
            end
            default: d_legal = 1'b0;
        endcase
        // Illegal bundles carry nothing but the flag and the PC.
        if (!d_legal) begin
            d_alu_op    = 5'd0;
            d_rs1       = 5'd0;
            d_rs2       = 5'd0;
            d_rd        = 5'd0;
            d_imm       = '0;
            d_alu_src   = 1'b0;
            d_reg_write = 1'b0;
            d_reg_read  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_pc        <= '0;
            out_alu_op    <= 5'd0;
            out_rs1       <= 5'd0;
            out_rs2       <= 5'd0;
            out_rd        <= 5'd0;
            out_imm       <= '0;
            out_alu_src   <= 1'b0;
            out_reg_write <= 1'b0;
            out_reg_read  <= 1'b0;
            out_illegal   <= 1'b0;
            ill_count     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_pc        <= in_pc;
            out_alu_op    <= d_alu_op;
            out_rs1       <= d_rs1;
            out_rs2       <= d_rs2;
            out_rd        <= d_rd;
            out_imm       <= d_imm;
            out_alu_src   <= d_alu_src;
            out_reg_write <= d_reg_write;
            out_reg_read  <= d_reg_read;
            out_illegal   <= !d_legal;
            if (!d_legal && ill_count != {ILL_CNT_W{1'b1}})
                ill_count <= ill_count + ILL_CNT_W'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
